// File: rtl/clkctrl_pkg.sv
// Shared types for the core clock/reset sequencer.
package clkctrl_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    HALT  = 2'd3
  } clk_state_t;

  // Plain-vector encodings for the state register
  localparam logic [1:0] S_RESET = 2'(RESET);
  localparam logic [1:0] S_RUN   = 2'(RUN);
  localparam logic [1:0] S_STEP  = 2'(STEP);
  localparam logic [1:0] S_HALT  = 2'(HALT);

endpackage

// File: rtl/core_clock_ctrl_if.sv
// Control/status bundle between the board-level logic and the core clock sequencer.
interface core_clock_ctrl_if #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 32
);
  import clkctrl_pkg::*;

  logic             key_rst_n;
  logic             key_step_n;
  logic             run_mode;
  logic [DIV_W-1:0] div_sel;
  logic             clkbreak;
  logic             rst_req;

  logic             core_rst;
  logic             core_tick;
  logic             core_clk;
  clk_state_t       state;
  logic [CNT_W-1:0] tick_count;

  modport master (
    output key_rst_n, key_step_n, run_mode, div_sel, clkbreak, rst_req,
    input  core_rst, core_tick, core_clk, state, tick_count
  );

  modport slave (
    input  key_rst_n, key_step_n, run_mode, div_sel, clkbreak, rst_req,
    output core_rst, core_tick, core_clk, state, tick_count
  );

endinterface

// File: rtl/button_debounce.sv
// Synchronises an active-low push button and debounces it; reports the held
// level and a one-cycle pulse on each accepted press.
module button_debounce #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic clk50,
  input  logic rst,
  input  logic btn_n,
  output logic pressed,
  output logic press_pulse
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pressed_q, pressed_d;
  logic          pulse_q, pulse_d;
  logic          sample_c;

  // Two-flop synchroniser; idles at "released"
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], btn_n};
  end

  assign sample_c = ~sync_q[1];

  // Accept a new level only after DEB_CYCLES consecutive differing samples
  always_comb begin
    cnt_d     = cnt_q;
    pressed_d = pressed_q;
    pulse_d   = 1'b0;
    if (sample_c == pressed_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d     = '0;
      pressed_d = sample_c;
      pulse_d   = sample_c;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      pulse_q   <= pulse_d;
    end
  end

  assign pressed     = pressed_q;
  assign press_pulse = pulse_q;

endmodule

// File: rtl/core_clock_ctrl.sv
// Clock-enable and reset sequencer for the CPU core, entirely in the clk50 domain.
// Generates divided/single-step ticks, halt-on-break and a stretched core reset.
module core_clock_ctrl
  import clkctrl_pkg::*;
#(
  parameter int unsigned DIV_W      = 8,
  parameter int unsigned POR_CYCLES = 33554432,
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned CNT_W      = 32
) (
  input logic              clk50,
  input logic              rst,
  core_clock_ctrl_if.slave bus
);

  localparam int unsigned     POR_W   = $clog2(POR_CYCLES + 1);
  localparam logic [POR_W-1:0] POR_MAX = POR_W'(POR_CYCLES);

  logic [1:0]       run_sync_q;
  logic             run_mode_s;
  logic             key_rst_held, key_rst_press;
  logic             step_held, step_press;

  logic [1:0]       state_q, state_d;
  logic [POR_W-1:0] por_cnt_q, por_cnt_d;
  logic             core_rst_q, core_rst_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             core_tick_q;
  logic             core_clk_q, core_clk_d;
  logic [CNT_W-1:0] tick_count_q, tick_count_d;

  logic             rst_src_c;
  logic             div_hit_c;
  logic             brk_c;
  logic             tick_c;

  // Run/step switch crosses in through a plain two-flop synchroniser
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) run_sync_q <= 2'b00;
    else     run_sync_q <= {run_sync_q[0], bus.run_mode};
  end

  assign run_mode_s = run_sync_q[1];

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rst (
    .clk50       (clk50),
    .rst         (rst),
    .btn_n       (bus.key_rst_n),
    .pressed     (key_rst_held),
    .press_pulse (key_rst_press)
  );

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .clk50       (clk50),
    .rst         (rst),
    .btn_n       (bus.key_step_n),
    .pressed     (step_held),
    .press_pulse (step_press)
  );

  // Reset stretch and free-running divider
  always_comb begin
    rst_src_c = bus.rst_req | key_rst_held | key_rst_press;

    por_cnt_d = por_cnt_q;
    if (rst_src_c)                 por_cnt_d = '0;
    else if (por_cnt_q != POR_MAX) por_cnt_d = por_cnt_q + POR_W'(1);
    core_rst_d = (por_cnt_d != POR_MAX);

    // Compare is live, so a shrunken div_sel below the count rolls over at all-ones
    div_hit_c = (div_cnt_q == bus.div_sel);
    div_cnt_d = div_hit_c ? '0 : div_cnt_q + DIV_W'(1);
  end

  // Next-state and tick selection
  always_comb begin
    state_d = state_q;
    tick_c  = 1'b0;
    brk_c   = bus.clkbreak & core_tick_q;

    case (state_q)
      S_RESET: begin
        tick_c = div_hit_c;
        if (!core_rst_d) state_d = run_mode_s ? S_RUN : S_STEP;
      end
      S_RUN: begin
        // The tick the core is breaking on is already out; hold back the next one
        tick_c = div_hit_c & ~brk_c;
        if (brk_c)            state_d = S_HALT;
        else if (!run_mode_s) state_d = S_STEP;
      end
      S_STEP: begin
        tick_c = step_press;
        if (run_mode_s) state_d = S_RUN;
      end
      S_HALT: begin
        tick_c = step_press;
        if (!run_mode_s)        state_d = S_STEP;
        else if (!bus.clkbreak) state_d = S_RUN;
      end
      default: state_d = S_RESET;
    endcase

    if (rst_src_c) state_d = S_RESET;

    core_clk_d   = core_clk_q ^ tick_c;
    tick_count_d = (state_d == S_RESET) ? '0 : tick_count_q + CNT_W'(tick_c);
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) state_q <= S_RESET;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      por_cnt_q    <= '0;
      core_rst_q   <= 1'b1;
      div_cnt_q    <= '0;
      core_tick_q  <= 1'b0;
      core_clk_q   <= 1'b0;
      tick_count_q <= '0;
    end else begin
      por_cnt_q    <= por_cnt_d;
      core_rst_q   <= core_rst_d;
      div_cnt_q    <= div_cnt_d;
      core_tick_q  <= tick_c;
      core_clk_q   <= core_clk_d;
      tick_count_q <= tick_count_d;
    end
  end

  assign bus.core_rst   = core_rst_q;
  assign bus.core_tick  = core_tick_q;
  assign bus.core_clk   = core_clk_q;
  assign bus.state      = clk_state_t'(state_q);
  assign bus.tick_count = tick_count_q;

endmodule

// File: tb/tb_core_clock_ctrl.sv
// Directed bench for core_clock_ctrl with POR_CYCLES=16, DEB_CYCLES=4.
module tb_core_clock_ctrl;

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STEP  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  logic clk50;
  logic rst;
  int   checks;
  int   errors;

  core_clock_ctrl_if #(.DIV_W(8), .CNT_W(32)) bus ();

  core_clock_ctrl #(
    .DIV_W      (8),
    .POR_CYCLES (16),
    .DEB_CYCLES (4),
    .CNT_W      (32)
  ) dut (
    .clk50 (clk50),
    .rst   (rst),
    .bus   (bus)
  );

  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk50);
    #1;
  endtask

  task automatic test_reset();
    logic exp;
    logic [1:0] exp_st;
    rst = 1'b1;
    bus.key_rst_n  = 1'b1;
    bus.key_step_n = 1'b1;
    bus.run_mode   = 1'b1;
    bus.div_sel    = 8'd3;
    bus.clkbreak   = 1'b0;
    bus.rst_req    = 1'b0;
    repeat (3) cyc();
    checks++; if (bus.core_rst !== 1'b1)     begin errors++; $display("FAIL reset core_rst got %b exp 1", bus.core_rst); end
    checks++; if (bus.state !== ST_RESET)    begin errors++; $display("FAIL reset state got %0d exp 0", bus.state); end
    checks++; if (bus.core_tick !== 1'b0)    begin errors++; $display("FAIL reset core_tick got %b exp 0", bus.core_tick); end
    checks++; if (bus.core_clk !== 1'b0)     begin errors++; $display("FAIL reset core_clk got %b exp 0", bus.core_clk); end
    checks++; if (bus.tick_count !== 32'd0)  begin errors++; $display("FAIL reset tick_count got %0d exp 0", bus.tick_count); end
    rst = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      cyc();
      exp = (k < 16);
      checks++; if (bus.core_rst !== exp) begin errors++; $display("FAIL por_stretch k=%0d core_rst got %b exp %b", k, bus.core_rst, exp); end
      exp = (k % 4 == 0);
      checks++; if (bus.core_tick !== exp) begin errors++; $display("FAIL div3_tick k=%0d core_tick got %b exp %b", k, bus.core_tick, exp); end
      exp_st = (k < 16) ? ST_RESET : ST_RUN;
      checks++; if (bus.state !== exp_st) begin errors++; $display("FAIL por_state k=%0d state got %0d exp %0d", k, bus.state, exp_st); end
      if (k == 13) begin
        checks++; if (bus.core_clk !== 1'b1) begin errors++; $display("FAIL reset_core_clk k=13 got %b exp 1", bus.core_clk); end
      end
    end
    checks++; if (bus.tick_count !== 32'd5) begin errors++; $display("FAIL tick_count_20 got %0d exp 5", bus.tick_count); end
    checks++; if (bus.core_clk !== 1'b0)    begin errors++; $display("FAIL core_clk_8ticks got %b exp 0", bus.core_clk); end
  endtask

  task automatic test_div0();
    logic        prev_clk;
    logic [31:0] tc0;
    bus.div_sel = 8'd0;
    repeat (300) cyc();
    prev_clk = bus.core_clk;
    tc0      = bus.tick_count;
    for (int k = 0; k < 8; k++) begin
      cyc();
      checks++; if (bus.core_tick !== 1'b1) begin errors++; $display("FAIL div0_tick k=%0d got %b exp 1", k, bus.core_tick); end
      checks++; if (bus.core_clk !== ~prev_clk) begin errors++; $display("FAIL div0_clk k=%0d got %b exp %b", k, bus.core_clk, ~prev_clk); end
      prev_clk = bus.core_clk;
    end
    checks++; if (bus.tick_count !== tc0 + 32'd8) begin errors++; $display("FAIL div0_count got %0d exp %0d", bus.tick_count, tc0 + 32'd8); end
  endtask

  task automatic test_step();
    int          n;
    logic        exp;
    logic [31:0] tc0;
    bus.run_mode = 1'b0;
    repeat (5) cyc();
    checks++; if (bus.state !== ST_STEP) begin errors++; $display("FAIL step_enter state got %0d exp 2", bus.state); end
    n = 0;
    repeat (10) begin cyc(); if (bus.core_tick) n++; end
    checks++; if (n !== 0) begin errors++; $display("FAIL step_suppress ticks got %0d exp 0", n); end
    tc0 = bus.tick_count;
    n = 0;
    for (int g = 0; g < 2; g++) begin
      bus.key_step_n = 1'b0;
      repeat (2) begin cyc(); if (bus.core_tick) n++; end
      bus.key_step_n = 1'b1;
      repeat (4) begin cyc(); if (bus.core_tick) n++; end
    end
    repeat (4) begin cyc(); if (bus.core_tick) n++; end
    checks++; if (n !== 0) begin errors++; $display("FAIL step_glitch ticks got %0d exp 0", n); end
    bus.key_step_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      exp = (k == 7);
      checks++; if (bus.core_tick !== exp) begin errors++; $display("FAIL step_latency k=%0d core_tick got %b exp %b", k, bus.core_tick, exp); end
    end
    bus.key_step_n = 1'b1;
    n = 0;
    repeat (15) begin cyc(); if (bus.core_tick) n++; end
    checks++; if (n !== 0) begin errors++; $display("FAIL step_release ticks got %0d exp 0", n); end
    checks++; if (bus.tick_count !== tc0 + 32'd1) begin errors++; $display("FAIL step_count got %0d exp %0d", bus.tick_count, tc0 + 32'd1); end
    checks++; if (bus.state !== ST_STEP) begin errors++; $display("FAIL step_stay state got %0d exp 2", bus.state); end
  endtask

  task automatic test_break();
    int          n;
    logic        found;
    logic [31:0] tc0;
    bus.run_mode = 1'b1;
    bus.div_sel  = 8'd1;
    repeat (5) cyc();
    checks++; if (bus.state !== ST_RUN) begin errors++; $display("FAIL break_run state got %0d exp 1", bus.state); end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc();
      if (bus.core_tick) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL break_wait_tick got %b exp 1", found); end
    tc0 = bus.tick_count;
    bus.clkbreak = 1'b1;
    cyc();
    checks++; if (bus.state !== ST_HALT) begin errors++; $display("FAIL break_halt state got %0d exp 3", bus.state); end
    checks++; if (bus.tick_count !== tc0) begin errors++; $display("FAIL break_count got %0d exp %0d", bus.tick_count, tc0); end
    n = 0;
    repeat (50) begin cyc(); if (bus.core_tick) n++; end
    checks++; if (n !== 0) begin errors++; $display("FAIL halt_quiet ticks got %0d exp 0", n); end
    n = 0;
    bus.key_step_n = 1'b0;
    repeat (8) begin cyc(); if (bus.core_tick) n++; end
    bus.key_step_n = 1'b1;
    repeat (15) begin cyc(); if (bus.core_tick) n++; end
    checks++; if (n !== 1) begin errors++; $display("FAIL halt_step ticks got %0d exp 1", n); end
    checks++; if (bus.state !== ST_HALT) begin errors++; $display("FAIL halt_step_state got %0d exp 3", bus.state); end
    checks++; if (bus.tick_count !== tc0 + 32'd1) begin errors++; $display("FAIL halt_step_count got %0d exp %0d", bus.tick_count, tc0 + 32'd1); end
    bus.clkbreak = 1'b0;
    cyc();
    checks++; if (bus.state !== ST_RUN) begin errors++; $display("FAIL halt_resume state got %0d exp 1", bus.state); end
  endtask

  task automatic test_rst_req();
    int         n;
    logic       exp;
    logic [1:0] exp_st;
    bus.rst_req = 1'b1;
    cyc();
    bus.rst_req = 1'b0;
    checks++; if (bus.core_rst !== 1'b1)    begin errors++; $display("FAIL swreset core_rst got %b exp 1", bus.core_rst); end
    checks++; if (bus.state !== ST_RESET)   begin errors++; $display("FAIL swreset state got %0d exp 0", bus.state); end
    checks++; if (bus.tick_count !== 32'd0) begin errors++; $display("FAIL swreset tick_count got %0d exp 0", bus.tick_count); end
    n = 0;
    for (int k = 2; k <= 30; k++) begin
      cyc();
      exp    = (k < 25);
      exp_st = (k < 25) ? ST_RESET : ST_RUN;
      checks++; if (bus.core_rst !== exp) begin errors++; $display("FAIL swreset_restart k=%0d core_rst got %b exp %b", k, bus.core_rst, exp); end
      checks++; if (bus.state !== exp_st) begin errors++; $display("FAIL swreset_state k=%0d got %0d exp %0d", k, bus.state, exp_st); end
      if (k < 25) begin
        if (bus.core_tick) n++;
        checks++; if (bus.tick_count !== 32'd0) begin errors++; $display("FAIL swreset_count k=%0d got %0d exp 0", k, bus.tick_count); end
      end
      if (k == 8) bus.rst_req = 1'b1;
      if (k == 9) bus.rst_req = 1'b0;
    end
    checks++; if (n < 11 || n > 12) begin errors++; $display("FAIL reset_ticks got %0d exp 11..12", n); end
  endtask

  task automatic test_key_rst();
    logic exp;
    bus.key_rst_n = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      cyc();
      exp = (k >= 7 && k < 52);
      checks++; if (bus.core_rst !== exp) begin errors++; $display("FAIL key_reset k=%0d core_rst got %b exp %b", k, bus.core_rst, exp); end
      if (k == 30) bus.key_rst_n = 1'b1;
    end
    checks++; if (bus.state !== ST_RUN) begin errors++; $display("FAIL key_reset_state got %0d exp 1", bus.state); end
  endtask

  task automatic test_async_rst();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc();
      if (bus.core_tick) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL async_wait_tick got %b exp 1", found); end
    bus.clkbreak = 1'b1;
    cyc();
    checks++; if (bus.state !== ST_HALT) begin errors++; $display("FAIL async_pre_halt state got %0d exp 3", bus.state); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.core_rst !== 1'b1)    begin errors++; $display("FAIL async core_rst got %b exp 1", bus.core_rst); end
    checks++; if (bus.state !== ST_RESET)   begin errors++; $display("FAIL async state got %0d exp 0", bus.state); end
    checks++; if (bus.core_tick !== 1'b0)   begin errors++; $display("FAIL async core_tick got %b exp 0", bus.core_tick); end
    checks++; if (bus.core_clk !== 1'b0)    begin errors++; $display("FAIL async core_clk got %b exp 0", bus.core_clk); end
    checks++; if (bus.tick_count !== 32'd0) begin errors++; $display("FAIL async tick_count got %0d exp 0", bus.tick_count); end
    bus.clkbreak = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_div0();
    test_step();
    test_break();
    test_rst_req();
    test_key_rst();
    test_async_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_clock_ctrl.md
Name: core_clock_ctrl

Overview:
Parametrised clock-enable and reset sequencer for the CPU core, running entirely in the clk50 domain. Generates a programmable-rate core tick, single-step ticks from a debounced button, and halt-on-breakpoint. Stretches power-on, key and software reset requests into a fixed-length core reset. Replaces ad-hoc divider/toggle logic at top level; core_clk is kept as a square-wave output for legacy consumers.

Parameters:
DIV_W, 8, width of run-mode divider select
POR_CYCLES, 33554432, clk50 cycles core_rst stays high after last reset source
DEB_CYCLES, 500000, clk50 cycles a button must be stable before accepted
CNT_W, 32, width of tick_count

Ports:
clk50  in  1  system clock, 50 MHz
rst  in  1  asynchronous active-high reset
key_rst_n  in  1  raw reset button, active-low, asynchronous
key_step_n  in  1  raw single-step button, active-low, asynchronous
run_mode  in  1  1 = free-run, 0 = single-step (asynchronous switch)
div_sel  in  DIV_W  tick period minus one, in clk50 cycles
clkbreak  in  1  breakpoint request from core, synchronous to clk50
rst_req  in  1  software reset request, one-cycle pulse
core_rst  out  1  stretched core reset, active-high
core_tick  out  1  one-cycle clock-enable pulse for core
core_clk  out  1  toggles on every core_tick
state  out  2  0 RESET, 1 RUN, 2 STEP, 3 HALT
tick_count  out  CNT_W  ticks issued since core_rst fell

Behaviour:
- rst asserted: all outputs 0 except core_rst=1 and state=RESET; POR counter=0; divider=0; debouncers cleared to "released".
- Input sync: key_rst_n, key_step_n and run_mode each pass through a 2-flop synchroniser. Buttons are debounced: output changes only after DEB_CYCLES consecutive equal samples. Press event = debounced rising edge of pressed state, 1 cycle.
- Reset stretch: rst_req pulse, key-reset press or debounced key held down clears the POR counter. core_rst=1 while counter<POR_CYCLES; counter saturates at POR_CYCLES; core_rst falls the cycle it saturates. A new source mid-stretch restarts the full count.
- Divider: counter 0..div_sel; core_tick=1 in the cycle the counter equals div_sel, then wraps to 0. div_sel=0 gives core_tick every cycle. A div_sel change takes effect at the next wrap; if the counter is already > new div_sel, it wraps at max value (no stall longer than 2^DIV_W).
- RESET: ticks run at the divider rate so synchronous core resets capture; tick_count held 0. On core_rst fall -> RUN if run_mode=1, else STEP.
- RUN: divider ticks pass to core_tick. run_mode=0 -> STEP. clkbreak=1 in a cycle with core_tick=1 -> HALT; that tick is still issued.
- STEP: divider free-runs, but ticks are suppressed. A step press issues exactly one core_tick in the following cycle, independent of the divider. run_mode=1 -> RUN.
- HALT: no divider ticks. A step press issues one tick; state stays HALT. clkbreak=0 with run_mode=1 -> RUN; run_mode=0 -> STEP.
- Any reset source in any state -> RESET on the next cycle (async rst immediately).
- Simultaneous events: a reset source wins over everything; clkbreak wins over a run_mode change in the same cycle.
- core_clk toggles on every core_tick, including ticks in RESET.
- tick_count increments on every core_tick outside RESET and wraps modulo 2^CNT_W.
- Latency: step press to core_tick is 1 cycle; button pin to press event is 2 + DEB_CYCLES cycles.

Decomposition:
- Package clkctrl_pkg holds typedef enum logic [1:0] clk_state_t {RESET, RUN, STEP, HALT}.
- One sub-module, button_debounce (params DEB_CYCLES; ports clk50, rst, btn_n, pressed, press_pulse), includes the 2-flop synchroniser. Instantiated twice.

Test Plan:
- Bench params POR_CYCLES=16, DEB_CYCLES=4. Release rst, run_mode=1, div_sel=3 -> core_rst high for 16 cycles; then state=RUN; core_tick every 4th cycle; tick_count=5 after 20 cycles.
- div_sel=0 in RUN -> core_tick high every cycle; core_clk period 2 cycles.
- run_mode=0; key_step_n low for 10 cycles, with 2-cycle glitches before it -> glitches ignored; exactly one core_tick, 7 cycles after the stable press starts; tick_count +1.
- RUN with div_sel=1; clkbreak=1 on a tick cycle -> that tick issued, state=HALT, no further ticks over 50 cycles; step press -> one tick; clkbreak=0 -> RUN.
- rst_req pulse at cycle 8 of a stretch, and again in RUN -> core_rst stays high 16 cycles after each pulse; tick_count=0; state RESET then RUN.
- Assert rst asynchronously mid-HALT -> outputs reset immediately, before the next clk50 edge.
